// File: rtl/intersection_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_phase_controller
//  Description : Timed phase sequencer for a two-road (EW / NS) intersection
//                with a pedestrian all-red walk phase. Min/max green with
//                gap-out, fixed yellow, all-red and walk intervals.
//  Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_controller #(
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 10,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 3,
    parameter int CNT_W        = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ew_car,
    input  logic       ns_car,
    input  logic       ped_req,
    output logic [2:0] ew_light,
    output logic [2:0] ns_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        EW_GREEN  = 3'd0,
        EW_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        NS_GREEN  = 3'd3,
        NS_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6
    } state_e;

    // Lamp codes {red,yellow,green}
    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    // Last timer value of each interval
    localparam logic [CNT_W-1:0] c_MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_YEL_LAST  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_RED_LAST  = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] c_WALK_LAST = CNT_W'(WALK_TIME - 1);

    // next_dir encoding: 0 = EW, 1 = NS
    localparam logic c_DIR_EW = 1'b0;
    localparam logic c_DIR_NS = 1'b1;

    // Kept as a plain vector so the unused code 7 is representable and recoverable
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_q, ped_d;
    logic             next_dir_q, next_dir_d;
    logic [2:0]       ew_q, ns_q;
    logic             walk_q, ack_q;

    logic             w_ew_demand;
    logic             w_ns_demand;
    logic             w_enter_walk;

    function automatic logic [2:0] ew_decode(input logic [2:0] s);
        case (s)
            EW_GREEN:  ew_decode = c_GRN;
            EW_YELLOW: ew_decode = c_YEL;
            default:   ew_decode = c_RED;
        endcase
    endfunction

    function automatic logic [2:0] ns_decode(input logic [2:0] s);
        case (s)
            NS_GREEN:  ns_decode = c_GRN;
            NS_YELLOW: ns_decode = c_YEL;
            default:   ns_decode = c_RED;
        endcase
    endfunction

    // Demand seen by the road currently holding green
    assign w_ew_demand  = ns_car | ped_q;
    assign w_ns_demand  = ew_car | ped_q;
    assign w_enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

    // Next-state, timer and pedestrian-latch logic
    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            EW_GREEN: begin
                if (w_ew_demand && (((timer_q >= c_MIN_LAST) && !ew_car) ||
                                    (timer_q == c_MAX_LAST)))
                    state_d = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (timer_q == c_YEL_LAST) state_d = ALL_RED_A;
            end
            ALL_RED_A: begin
                if (timer_q == c_RED_LAST) begin
                    next_dir_d = c_DIR_NS;
                    state_d    = ped_q ? PED_WALK : NS_GREEN;
                end
            end
            NS_GREEN: begin
                if (w_ns_demand && (((timer_q >= c_MIN_LAST) && !ns_car) ||
                                    (timer_q == c_MAX_LAST)))
                    state_d = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (timer_q == c_YEL_LAST) state_d = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (timer_q == c_RED_LAST) begin
                    next_dir_d = c_DIR_EW;
                    state_d    = ped_q ? PED_WALK : EW_GREEN;
                end
            end
            PED_WALK: begin
                if (timer_q == c_WALK_LAST)
                    state_d = (next_dir_q == c_DIR_NS) ? NS_GREEN : EW_GREEN;
            end
            default: state_d = EW_GREEN;
        endcase

        // Timer restarts on any phase change and saturates instead of wrapping
        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q != c_MAX_LAST)
            timer_d = timer_q + CNT_W'(1);
        else
            timer_d = timer_q;

        // Clearing on walk entry takes priority over a same-cycle request
        if (w_enter_walk)
            ped_d = 1'b0;
        else
            ped_d = ped_q | (ped_req && (state_q != PED_WALK));
    end

    // State registers; lamp outputs are registered from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EW_GREEN;
            timer_q    <= '0;
            ped_q      <= 1'b0;
            next_dir_q <= c_DIR_NS;
            ew_q       <= c_GRN;
            ns_q       <= c_RED;
            walk_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_q      <= ped_d;
            next_dir_q <= next_dir_d;
            ew_q       <= ew_decode(state_d);
            ns_q       <= ns_decode(state_d);
            walk_q     <= (state_d == PED_WALK);
            ack_q      <= w_enter_walk;
        end
    end

    assign ew_light = ew_q;
    assign ns_light = ns_q;
    assign walk     = walk_q;
    assign ped_ack  = ack_q;
    assign phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_phase_controller
//  Description : Scoreboard bench for intersection_phase_controller. The
//                driver pushes the hand-derived expected phase/lamp state of
//                every cycle; a monitor pops and compares on each sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_controller;

    logic       clock;
    logic       reset_n;
    logic       ew_car;
    logic       ns_car;
    logic       ped_req;
    logic [2:0] ew_light;
    logic [2:0] ns_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] ew;
        logic [2:0] ns;
        logic       wk;
        logic       ack;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  async_ev;

    intersection_phase_controller dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ew_car   (ew_car),
        .ns_car   (ns_car),
        .ped_req  (ped_req),
        .ew_light (ew_light),
        .ns_light (ns_light),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .phase    (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand table of lamp patterns per phase code
    function automatic exp_t mk(input logic [2:0] ph, input logic ack);
        exp_t e;
        e.ph  = ph;
        e.ack = ack;
        e.wk  = (ph == 3'd6);
        case (ph)
            3'd0:    begin e.ew = 3'b001; e.ns = 3'b100; end
            3'd1:    begin e.ew = 3'b010; e.ns = 3'b100; end
            3'd3:    begin e.ew = 3'b100; e.ns = 3'b001; end
            3'd4:    begin e.ew = 3'b100; e.ns = 3'b010; end
            default: begin e.ew = 3'b100; e.ns = 3'b100; end
        endcase
        return e;
    endfunction

    // One cycle: drive inputs just after the edge and record the expected state of this cycle
    task automatic cyc(input logic rn, input logic e, input logic n, input logic p,
                       input logic [2:0] ph, input logic ack, input string tag);
        @(posedge clock);
        #1;
        reset_n = rn;
        ew_car  = e;
        ns_car  = n;
        ped_req = p;
        exp_q.push_back(mk(ph, ack));
        tag_q.push_back(tag);
    endtask

    task automatic run(input int len, input logic e, input logic n,
                       input logic [2:0] ph, input string tag);
        for (int i = 0; i < len; i++) cyc(1'b1, e, n, 1'b0, ph, 1'b0, tag);
    endtask

    // Monitor: compares on every falling edge and on explicit async sample requests
    initial begin : monitor
        forever begin
            @(negedge clock or async_ev);
            if (exp_q.size() > 0) begin
                exp_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_cmp++;
                if ({phase, ew_light, ns_light, walk, ped_ack} !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got phase=%0d ew=%b ns=%b walk=%b ack=%b, want phase=%0d ew=%b ns=%b walk=%b ack=%b",
                             t, $time, phase, ew_light, ns_light, walk, ped_ack,
                             e.ph, e.ew, e.ns, e.wk, e.ack);
                end
            end
        end
    end

    initial begin : driver
        reset_n = 1'b0;
        ew_car  = 1'b0;
        ns_car  = 1'b0;
        ped_req = 1'b0;

        // Reset held, then idle with no inputs
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "reset_hold");
        run(20, 1'b0, 1'b0, 3'd0, "idle_rest");

        // NS demand only: gap-out after minimum green
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "reset2");
        run(4, 1'b0, 1'b1, 3'd0, "ns_dem_ewg");
        run(2, 1'b0, 1'b1, 3'd1, "ns_dem_ewy");
        run(1, 1'b0, 1'b1, 3'd2, "ns_dem_ar");
        run(5, 1'b0, 1'b1, 3'd3, "ns_dem_nsg");

        // Both roads occupied: alternate at max-out
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "reset3");
        run(10, 1'b1, 1'b1, 3'd0, "both_ewg");
        run(2,  1'b1, 1'b1, 3'd1, "both_ewy");
        run(1,  1'b1, 1'b1, 3'd2, "both_ara");
        run(10, 1'b1, 1'b1, 3'd3, "both_nsg");
        run(2,  1'b1, 1'b1, 3'd4, "both_nsy");
        run(1,  1'b1, 1'b1, 3'd5, "both_arb");
        run(10, 1'b1, 1'b1, 3'd0, "both_ewg2");
        run(2,  1'b1, 1'b1, 3'd1, "both_ewy2");

        // Pedestrian request at cycle 1, second request during walk ignored
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "reset4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "ped_ewg");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "ped_ewg");
        run(2, 1'b0, 1'b0, 3'd0, "ped_ewg");
        run(2, 1'b0, 1'b0, 3'd1, "ped_ewy");
        run(1, 1'b0, 1'b0, 3'd2, "ped_ara");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, "ped_walk_ack");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, "ped_walk");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, "ped_walk");
        run(6, 1'b0, 1'b0, 3'd3, "ped_nsg");

        // Pending request pushes NS into yellow, then async reset mid-yellow
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, "arst_nsg");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, "arst_nsg");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, "arst_nsy");
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(mk(3'd0, 1'b0));
        tag_q.push_back("arst_immediate");
        -> async_ev;
        // A surviving request would gap out to yellow after minimum green
        run(12, 1'b0, 1'b0, 3'd0, "arst_ped_clear");

        // Illegal encoding recovers to EW_GREEN on the next edge
        @(negedge clock);
        #1;
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        run(4, 1'b0, 1'b0, 3'd0, "illegal_recover");

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
